fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin arbiter that shares the single write port of a SyncFIFO among NREQ requesters, granting the port for bounded bursts. It sits in front of the FIFO's write side and drives the FIFO's `din`/`wr_en` while honouring `full`. Bursts end on a requester-marked last word or after MAX_BURST words, whichever comes first, so no requester can starve the others.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, data word width; matches the FIFO WIDTH
- MAX_BURST, 20, maximum words per grant (1..255)

- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  requester k has a word on its data lane
- req_data  in  NREQ*WIDTH  lane k = bits [k*WIDTH +: WIDTH]
- req_last  in  NREQ  current word of requester k is its last of the burst
- req_ready  out  NREQ  word of requester k accepted this cycle when valid&ready
- fifo_full  in  1  FIFO full flag
- fifo_din  out  WIDTH  FIFO write data
- fifo_wr_en  out  1  FIFO write enable
- grant  out  NREQ  one-hot registered grant; all-zero when idle
- busy  out  1  high in BURST state
- burst_cnt  out  8  words accepted in current burst

## Operation
- FSM states: IDLE, BURST.
- IDLE: grant=0. If any req_valid is high, pick the first k with req_valid[k]=1 searching upward from rr_ptr, wrapping modulo NREQ; register grant=onehot(k), burst_cnt=0, go to BURST. Otherwise stay.
- BURST, granted k:
  - req_ready[k] = !fifo_full; all other req_ready bits are 0.
  - accept = req_valid[k] & !fifo_full.
  - fifo_wr_en = accept; fifo_din = lane k (combinational pass-through).
  - On accept, burst_cnt increments.
  - End condition: accept & (req_last[k] | burst_cnt == MAX_BURST-1). On end, go to IDLE, clear grant, set rr_ptr = (k+1) mod NREQ, clear burst_cnt.
  - A gap in req_valid[k] keeps the grant and holds burst_cnt. The requester owns the port until it completes.
  - fifo_full stalls the burst: no accept, counter holds, grant holds.
- Outside BURST, fifo_din = 0, fifo_wr_en = 0 and req_ready = 0.
- rr_ptr is log2(NREQ) bits wide and wraps from NREQ-1 to 0.
- Reset (asynchronous, at any time including mid-burst) forces:
  - state=IDLE, rr_ptr=0;
  - grant, busy, burst_cnt = 0;
  - fifo_wr_en, req_ready, fifo_din = 0.
- A partially written burst is abandoned on reset; the FIFO is reset alongside.

## Timing
- Arbitration latency: req_valid seen in IDLE at cycle t produces grant at t+1. The first word can be written at t+1.
- Inter-burst bubble: the last accepted word at t is followed by IDLE at t+1. The next grant is visible at t+2. Exactly one idle cycle between bursts, even when requests are pending.
- fifo_wr_en and req_ready are combinational from fifo_full and req_valid in BURST. There is no added latency and no write is ever issued while fifo_full=1.
- Simultaneous req_last and burst_cnt == MAX_BURST-1 on the same accept is a single end event.
- MAX_BURST=1 ends every burst after one word.
- A requester that raises req_valid while another holds the grant waits. Its worst-case wait is (NREQ-1) bursts plus their bubbles, excluding full stalls.

## Test plan
- Single requester: after reset, req_valid[2]=1 with words 0..4 and req_last on word 4 -> grant=0100 one cycle later. FIFO receives 0,1,2,3,4 on consecutive cycles, then grant=0 for one cycle, and burst_cnt returns to 0.
- Round robin: all four requesters continuously valid, each asserting last on its 3rd word -> grant order 0001, 0010, 0100, 1000, 0001. Each burst is exactly 3 writes, separated by exactly one idle cycle.
- Burst cap: MAX_BURST=20, requester 1 streams 30 words with no req_last, requester 3 also valid -> after 20 writes grant passes to requester 3. Requester 1 resumes only after requester 3's burst ends.
- Full backpressure: force fifo_full=1 for 4 cycles mid-burst at burst_cnt=6 -> fifo_wr_en=0 and req_ready=0 for those 4 cycles and burst_cnt holds at 6. On release the burst continues with no lost or duplicated word.
- Valid gap: granted requester drops req_valid for 3 cycles -> grant holds, no writes, and the burst then completes normally.
- Reset mid-burst: assert rst low asynchronously at burst_cnt=7 -> grant, busy, burst_cnt, fifo_wr_en and req_ready drop to 0 immediately. After release with all requesters valid, requester 0 is granted first (rr_ptr=0).

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ requesters.
// A grant lasts one burst: until the requester's last word or MAX_BURST words, whichever is first.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  input  logic [NREQ-1:0]         req_last,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    fifo_full,
  output logic [WIDTH-1:0]        fifo_din,
  output logic                    fifo_wr_en,
  output logic [NREQ-1:0]         grant,
  output logic                    busy,
  output logic [7:0]              burst_cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Handshake: a word of requester k moves into the FIFO in exactly the
  // cycle where req_valid[k] & req_ready[k]; that same cycle fifo_wr_en=1.
  // busy is the FSM state bit (1 = BURST) and serves as its debug view.
  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   gidx;
  logic [PW-1:0]   pick_idx;
  logic            pick_found;
  logic [PW:0]     cand;
  logic [WIDTH-1:0] lane;
  logic            sel_valid;
  logic            sel_last;
  logic            accept;
  logic            burst_end;

  // First valid requester at or above rr_ptr, wrapping modulo NREQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = rr_ptr;
    cand       = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, rr_ptr} + (PW+1)'(i);
      if (cand >= (PW+1)'(NREQ)) cand = cand - (PW+1)'(NREQ);
      if (!pick_found && req_valid[cand[PW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[PW-1:0];
      end
    end
  end

  // The one-hot grant steers the lane mux; with grant=0 everything reads 0.
  always_comb begin
    lane      = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        lane      = req_data[k*WIDTH +: WIDTH];
        sel_valid = req_valid[k];
        sel_last  = req_last[k];
      end
    end
  end

  assign busy       = (state == BURST);
  assign accept     = busy & sel_valid & ~fifo_full;
  assign burst_end  = accept & (sel_last | (burst_cnt == 8'(MAX_BURST - 1)));
  assign req_ready  = (busy && !fifo_full) ? grant : '0;
  assign fifo_wr_en = accept;
  assign fifo_din   = busy ? lane : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gidx      <= '0;
      grant     <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state     <= BURST;
            gidx      <= pick_idx;
            grant     <= NREQ'(1) << pick_idx;
            burst_cnt <= '0;
          end
        end
        BURST: begin
          if (burst_end) begin
            state     <= IDLE;
            grant     <= '0;
            burst_cnt <= '0;
            rr_ptr    <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
          end else if (accept) begin
            burst_cnt <= burst_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: one task per scenario, inline checks
// against hand-computed per-cycle expectations.
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4;
  localparam int WIDTH = 8;
  localparam int MAX_BURST = 20;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ*WIDTH-1:0] req_data = '0;
  logic [NREQ-1:0]       req_last = '0;
  logic [NREQ-1:0]       req_ready;
  logic                  fifo_full = 1'b0;
  logic [WIDTH-1:0]      fifo_din;
  logic                  fifo_wr_en;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic [7:0]            burst_cnt;

  int n_cmp = 0;
  int n_err = 0;

  fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en), .grant(grant),
    .busy(busy), .burst_cnt(burst_cnt)
  );

  always #5 clk = ~clk;

  task automatic set_lane(input int k, input logic [WIDTH-1:0] v);
    req_data[k*WIDTH +: WIDTH] = v;
  endtask

  // Ends on a falling edge with rst released and all inputs idle.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    req_valid = 4'hf;
    @(negedge clk); #1;
    n_cmp++; if (grant !== 4'b0)      begin n_err++; $display("FAIL reset_grant got %b exp 0000", grant); end
    n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_cmp++; if (burst_cnt !== 8'd0)  begin n_err++; $display("FAIL reset_cnt got %0d exp 0", burst_cnt); end
    n_cmp++; if (fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en got %b exp 0", fifo_wr_en); end
    n_cmp++; if (req_ready !== 4'b0)  begin n_err++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    n_cmp++; if (fifo_din !== 8'd0)   begin n_err++; $display("FAIL reset_din got %h exp 00", fifo_din); end
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0100; set_lane(2, 8'd0);
    #1;
    n_cmp++; if (grant !== 4'b0000 || fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL single_idle grant %b wr_en %b exp 0000 0", grant, fifo_wr_en); end
    for (int w = 0; w < 5; w++) begin
      @(negedge clk);
      set_lane(2, 8'(w)); req_last = (w == 4) ? 4'b0100 : 4'b0000;
      #1;
      n_cmp++; if (grant !== 4'b0100)    begin n_err++; $display("FAIL single_grant w=%0d got %b exp 0100", w, grant); end
      n_cmp++; if (fifo_wr_en !== 1'b1)  begin n_err++; $display("FAIL single_wr_en w=%0d got %b exp 1", w, fifo_wr_en); end
      n_cmp++; if (fifo_din !== 8'(w))   begin n_err++; $display("FAIL single_din w=%0d got %0d exp %0d", w, fifo_din, w); end
      n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL single_ready w=%0d got %b exp 0100", w, req_ready); end
      n_cmp++; if (burst_cnt !== 8'(w))  begin n_err++; $display("FAIL single_cnt w=%0d got %0d exp %0d", w, burst_cnt, w); end
    end
    @(negedge clk);
    req_valid = '0; req_last = '0;
    #1;
    n_cmp++; if (grant !== 4'b0 || busy !== 1'b0 || burst_cnt !== 8'd0) begin n_err++; $display("FAIL single_end grant %b busy %b cnt %0d exp 0000 0 0", grant, busy, burst_cnt); end
  endtask

  task automatic test_round_robin();
    int pos;
    logic [NREQ-1:0] exp_g;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      pos = c % 4;
      req_valid = 4'hf;
      for (int k = 0; k < NREQ; k++) set_lane(k, (pos > 0) ? 8'(k*16 + pos - 1) : 8'd0);
      req_last = (pos == 3) ? 4'hf : 4'h0;
      #1;
      if (pos == 0) begin
        n_cmp++; if (grant !== 4'b0 || fifo_wr_en !== 1'b0 || fifo_din !== 8'd0) begin n_err++; $display("FAIL rr_idle c=%0d grant %b wr_en %b din %h exp 0000 0 00", c, grant, fifo_wr_en, fifo_din); end
      end else begin
        exp_g = 4'b0001 << ((c / 4) % 4);
        n_cmp++; if (grant !== exp_g) begin n_err++; $display("FAIL rr_grant c=%0d got %b exp %b", c, grant, exp_g); end
        n_cmp++; if (fifo_wr_en !== 1'b1 || fifo_din !== 8'(((c/4)%4)*16 + pos - 1)) begin n_err++; $display("FAIL rr_write c=%0d wr_en %b din %h exp 1 %h", c, fifo_wr_en, fifo_din, 8'(((c/4)%4)*16 + pos - 1)); end
        n_cmp++; if (burst_cnt !== 8'(pos - 1)) begin n_err++; $display("FAIL rr_cnt c=%0d got %0d exp %0d", c, burst_cnt, pos - 1); end
      end
    end
  endtask

  task automatic test_burst_cap();
    int w1 = 0;
    int w3 = 0;
    logic [NREQ-1:0] exp_g;
    logic [7:0] exp_d, exp_c;
    do_reset();
    req_valid = 4'b1010;
    for (int c = 0; c < 27; c++) begin
      if (c > 0) @(negedge clk);
      set_lane(1, 8'(w1)); set_lane(3, 8'(8'hA0 + w3));
      req_last = (w3 == 1) ? 4'b1000 : 4'b0000;
      #1;
      if (c == 0 || c == 21 || c == 24) begin
        n_cmp++; if (grant !== 4'b0 || fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL cap_idle c=%0d grant %b wr_en %b exp 0000 0", c, grant, fifo_wr_en); end
      end else begin
        if (c >= 22 && c <= 23) begin exp_g = 4'b1000; exp_d = 8'(8'hA0 + w3); exp_c = 8'(c - 22); w3++; end
        else if (c >= 25)       begin exp_g = 4'b0010; exp_d = 8'(w1); exp_c = 8'(c - 25); w1++; end
        else                    begin exp_g = 4'b0010; exp_d = 8'(w1); exp_c = 8'(c - 1); w1++; end
        n_cmp++; if (grant !== exp_g) begin n_err++; $display("FAIL cap_grant c=%0d got %b exp %b", c, grant, exp_g); end
        n_cmp++; if (fifo_wr_en !== 1'b1 || fifo_din !== exp_d) begin n_err++; $display("FAIL cap_write c=%0d wr_en %b din %h exp 1 %h", c, fifo_wr_en, fifo_din, exp_d); end
        n_cmp++; if (burst_cnt !== exp_c) begin n_err++; $display("FAIL cap_cnt c=%0d got %0d exp %0d", c, burst_cnt, exp_c); end
      end
    end
  endtask

  task automatic test_full_backpressure();
    int w = 0;
    do_reset();
    req_valid = 4'b0001;
    for (int c = 0; c < 18; c++) begin
      if (c > 0) @(negedge clk);
      fifo_full = (c >= 7 && c <= 10);
      set_lane(0, 8'(w)); req_last = (w == 11) ? 4'b0001 : 4'b0000;
      #1;
      if (c == 0 || c == 17) begin
        n_cmp++; if (grant !== 4'b0 || fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL full_idle c=%0d grant %b wr_en %b exp 0000 0", c, grant, fifo_wr_en); end
      end else if (fifo_full) begin
        n_cmp++; if (fifo_wr_en !== 1'b0 || req_ready !== 4'b0) begin n_err++; $display("FAIL full_stall c=%0d wr_en %b ready %b exp 0 0000", c, fifo_wr_en, req_ready); end
        n_cmp++; if (burst_cnt !== 8'd6 || grant !== 4'b0001) begin n_err++; $display("FAIL full_hold c=%0d cnt %0d grant %b exp 6 0001", c, burst_cnt, grant); end
      end else begin
        n_cmp++; if (fifo_wr_en !== 1'b1 || fifo_din !== 8'(w) || req_ready !== 4'b0001) begin n_err++; $display("FAIL full_write c=%0d wr_en %b din %0d ready %b exp 1 %0d 0001", c, fifo_wr_en, fifo_din, req_ready, w); end
        n_cmp++; if (burst_cnt !== 8'(w)) begin n_err++; $display("FAIL full_cnt c=%0d got %0d exp %0d", c, burst_cnt, w); end
        w++;
      end
    end
    fifo_full = 1'b0;
  endtask

  task automatic test_valid_gap();
    int w = 0;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      if (c > 0) @(negedge clk);
      req_valid = (c >= 3 && c <= 5) ? 4'b0000 : 4'b0100;
      set_lane(2, 8'(w)); req_last = (w == 3) ? 4'b0100 : 4'b0000;
      #1;
      if (c == 0 || c == 8) begin
        n_cmp++; if (grant !== 4'b0 || fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL gap_idle c=%0d grant %b wr_en %b exp 0000 0", c, grant, fifo_wr_en); end
      end else if (c >= 3 && c <= 5) begin
        n_cmp++; if (grant !== 4'b0100 || fifo_wr_en !== 1'b0 || burst_cnt !== 8'd2) begin n_err++; $display("FAIL gap_hold c=%0d grant %b wr_en %b cnt %0d exp 0100 0 2", c, grant, fifo_wr_en, burst_cnt); end
      end else begin
        n_cmp++; if (grant !== 4'b0100 || fifo_wr_en !== 1'b1 || fifo_din !== 8'(w) || burst_cnt !== 8'(w)) begin n_err++; $display("FAIL gap_write c=%0d grant %b wr_en %b din %0d cnt %0d exp 0100 1 %0d %0d", c, grant, fifo_wr_en, fifo_din, burst_cnt, w, w); end
        w++;
      end
    end
  endtask

  // last coincides with the 20th word: one end event, one bubble, regrant.
  task automatic test_last_at_cap();
    int w = 0;
    do_reset();
    req_valid = 4'b0001;
    for (int c = 0; c < 23; c++) begin
      if (c > 0) @(negedge clk);
      set_lane(0, 8'(w)); req_last = (w == MAX_BURST - 1) ? 4'b0001 : 4'b0000;
      #1;
      if (c == 0 || c == 21) begin
        n_cmp++; if (grant !== 4'b0 || busy !== 1'b0 || fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL lastcap_idle c=%0d grant %b busy %b wr_en %b exp 0000 0 0", c, grant, busy, fifo_wr_en); end
      end else begin
        n_cmp++; if (grant !== 4'b0001 || fifo_wr_en !== 1'b1 || fifo_din !== 8'(w)) begin n_err++; $display("FAIL lastcap_write c=%0d grant %b wr_en %b din %0d exp 0001 1 %0d", c, grant, fifo_wr_en, fifo_din, w); end
        n_cmp++; if (burst_cnt !== 8'((c >= 22) ? c - 22 : c - 1)) begin n_err++; $display("FAIL lastcap_cnt c=%0d got %0d exp %0d", c, burst_cnt, (c >= 22) ? c - 22 : c - 1); end
        w++;
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req_valid = 4'hf; req_last = '0;
    for (int c = 0; c < 9; c++) begin
      if (c > 0) @(negedge clk);
      set_lane(0, 8'(c));
      #1;
      if (c == 8) begin
        n_cmp++; if (burst_cnt !== 8'd7 || grant !== 4'b0001) begin n_err++; $display("FAIL rstmid_pre cnt %0d grant %b exp 7 0001", burst_cnt, grant); end
      end
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (grant !== 4'b0 || busy !== 1'b0 || burst_cnt !== 8'd0) begin n_err++; $display("FAIL rstmid_state grant %b busy %b cnt %0d exp 0000 0 0", grant, busy, burst_cnt); end
    n_cmp++; if (fifo_wr_en !== 1'b0 || req_ready !== 4'b0 || fifo_din !== 8'd0) begin n_err++; $display("FAIL rstmid_outs wr_en %b ready %b din %h exp 0 0000 00", fifo_wr_en, req_ready, fifo_din); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (grant !== 4'b0) begin n_err++; $display("FAIL rstmid_idle grant %b exp 0000", grant); end
    @(negedge clk); #1;
    n_cmp++; if (grant !== 4'b0001 || burst_cnt !== 8'd0 || fifo_wr_en !== 1'b1) begin n_err++; $display("FAIL rstmid_regrant grant %b cnt %0d wr_en %b exp 0001 0 1", grant, burst_cnt, fifo_wr_en); end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_burst_cap();
    test_full_backpressure();
    test_valid_gap();
    test_last_at_cap();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
